// File: rtl/tqvp_alonso_rsa_dec_if.sv
// Register bus between the TinyQV core and the RSA decryption peripheral.
// The core is the master; the peripheral answers reads combinationally.
interface tqvp_alonso_rsa_dec_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/tqvp_alonso_rsa_dec.sv
// 8-bit RSA decryption peripheral: RESULT = CIPHER^DEXP mod MODN.
// Left-to-right square-and-multiply, each modular multiply done bit-serially over 8 clocks.
module tqvp_alonso_rsa_dec (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  ui_in,
    output logic [7:0]                  uo_out,
    tqvp_alonso_rsa_dec_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, SQR, MUL} state_t;

    state_t     state;
    logic [7:0] test_reg;
    logic [7:0] cipher;
    logic [7:0] dexp;
    logic [7:0] modn;
    logic [7:0] result;
    logic       done;
    logic       busy;
    logic       err;

    logic [7:0] c_s;
    logic [7:0] d_s;
    logic [7:0] n_s;
    logic [7:0] r;
    logic [7:0] acc;
    logic [2:0] bit_idx;
    logic [2:0] step;

    logic       cmd_write;
    logic       start_req;
    logic       abort_req;
    logic       operands_bad;

    logic [7:0] mul_b;
    logic       b_bit;
    logic [8:0] n9;
    logic [8:0] dbl;
    logic [8:0] dbl_red;
    logic [8:0] sum;
    logic [7:0] acc_next;
    logic [7:0] read_data;
    logic       unused_in;

    assign unused_in    = ^ui_in;
    assign cmd_write    = bus.data_write && (bus.address == 4'h1);
    assign start_req    = cmd_write && bus.data_in[0];
    assign abort_req    = cmd_write && bus.data_in[1];
    assign operands_bad = (modn < 8'd2) || (cipher >= modn);

    // One interleaved step: double-and-reduce, then conditionally add r and reduce.
    // Operands stay below N, so a single subtraction always suffices.
    always_comb begin
        mul_b   = (state == MUL) ? c_s : r;
        b_bit   = mul_b[step];
        n9      = {1'b0, n_s};
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= n9) ? (dbl - n9) : dbl;
        sum     = dbl_red + (b_bit ? {1'b0, r} : 9'd0);
        acc_next = (sum >= n9) ? 8'(sum - n9) : sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            test_reg <= 8'h00;
            cipher   <= 8'h00;
            dexp     <= 8'h00;
            modn     <= 8'h00;
            result   <= 8'h00;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            c_s      <= 8'h00;
            d_s      <= 8'h00;
            n_s      <= 8'h00;
            r        <= 8'h00;
            acc      <= 8'h00;
            bit_idx  <= 3'd0;
            step     <= 3'd0;
        end else begin
            if (bus.data_write) begin
                case (bus.address)
                    4'h0:    test_reg <= bus.data_in;
                    4'h2:    cipher   <= bus.data_in;
                    4'h3:    dexp     <= bus.data_in;
                    4'h4:    modn     <= bus.data_in;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        done <= 1'b0;
                        err  <= 1'b0;
                        if (operands_bad) begin
                            err    <= 1'b1;
                            done   <= 1'b1;
                            result <= 8'h00;
                        end else begin
                            c_s     <= cipher;
                            d_s     <= dexp;
                            n_s     <= modn;
                            r       <= 8'd1;
                            acc     <= 8'h00;
                            bit_idx <= 3'd7;
                            step    <= 3'd7;
                            busy    <= 1'b1;
                            state   <= SQR;
                        end
                    end
                end
                SQR, MUL: begin
                    if (abort_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end else begin
                        acc  <= acc_next;
                        step <= step - 3'd1;
                        // Last step of a multiply: commit R and pick the next operation.
                        if (step == 3'd0) begin
                            acc  <= 8'h00;
                            step <= 3'd7;
                            r    <= acc_next;
                            if ((state == SQR) && d_s[bit_idx]) begin
                                state <= MUL;
                            end else if (bit_idx == 3'd0) begin
                                result <= acc_next;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                bit_idx <= bit_idx - 3'd1;
                                state   <= SQR;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        read_data = 8'h00;
        case (bus.address)
            4'h0:    read_data = test_reg;
            4'h2:    read_data = cipher;
            4'h3:    read_data = dexp;
            4'h4:    read_data = modn;
            4'h5:    read_data = result;
            4'h6:    read_data = {5'b00000, err, busy, done};
            default: read_data = 8'h00;
        endcase
    end

    assign bus.data_out = read_data;
    assign uo_out       = result;

endmodule
